// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: active-high glyph patterns
// and the all-segments-dark pattern. Polarity is applied by the top module.
// Segment bit order everywhere is {a,b,c,d,e,f,g}: a = bit 6 ... g = bit 0.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF    = 7'b0000000;

  localparam logic [6:0] GLYPH_0    = 7'b1111110;
  localparam logic [6:0] GLYPH_1    = 7'b0110000;
  localparam logic [6:0] GLYPH_2    = 7'b1101101;
  localparam logic [6:0] GLYPH_3    = 7'b1111001;
  localparam logic [6:0] GLYPH_4    = 7'b0110011;
  localparam logic [6:0] GLYPH_5    = 7'b1011011;
  localparam logic [6:0] GLYPH_6    = 7'b1011111;
  localparam logic [6:0] GLYPH_7    = 7'b1110000;
  localparam logic [6:0] GLYPH_8    = 7'b1111111;
  localparam logic [6:0] GLYPH_9    = 7'b1111011;
  localparam logic [6:0] GLYPH_A    = 7'b1110111;
  localparam logic [6:0] GLYPH_B    = 7'b0011111;
  localparam logic [6:0] GLYPH_C    = 7'b1001110;
  localparam logic [6:0] GLYPH_D    = 7'b0111101;
  localparam logic [6:0] GLYPH_E    = 7'b1001111;
  localparam logic [6:0] GLYPH_F    = 7'b1000111;
  // Shown for nibbles 10..15 when hex glyphs are disabled (segment g only).
  localparam logic [6:0] GLYPH_DASH = 7'b0000001;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational nibble-to-segment decoder. Output is active-high {a..g};
// hex_mode=0 maps nibbles 10..15 to a dash.
module seg7_glyph_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] pattern
);

  // Glyph lookup; the dash default covers non-decimal nibbles in BCD mode.
  always_comb begin
    pattern = GLYPH_DASH;
    case (nibble)
      4'h0: pattern = GLYPH_0;
      4'h1: pattern = GLYPH_1;
      4'h2: pattern = GLYPH_2;
      4'h3: pattern = GLYPH_3;
      4'h4: pattern = GLYPH_4;
      4'h5: pattern = GLYPH_5;
      4'h6: pattern = GLYPH_6;
      4'h7: pattern = GLYPH_7;
      4'h8: pattern = GLYPH_8;
      4'h9: pattern = GLYPH_9;
      4'hA: pattern = hex_mode ? GLYPH_A : GLYPH_DASH;
      4'hB: pattern = hex_mode ? GLYPH_B : GLYPH_DASH;
      4'hC: pattern = hex_mode ? GLYPH_C : GLYPH_DASH;
      4'hD: pattern = hex_mode ? GLYPH_D : GLYPH_DASH;
      4'hE: pattern = hex_mode ? GLYPH_E : GLYPH_DASH;
      4'hF: pattern = hex_mode ? GLYPH_F : GLYPH_DASH;
      default: pattern = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. A prescaler divides clk into
// digit slots; a digit counter walks the digits. Loaded values are staged in a
// pending register and promoted to the displayed shadow register only at the
// frame boundary, so one frame never mixes two loaded values.
//
// load semantics: single-cycle strobe with no backpressure. value/dp_mask are
// sampled on every rising edge where load=1; the last load before a frame
// boundary wins, and a load on the boundary edge itself goes straight to the
// displayed value.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_MODE       = 1,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]       DIGIT_LAST = DW'(N_DIGITS - 1);
  localparam logic                SEG_INV    = (ACTIVE_LOW_SEG != 0);
  localparam logic                AN_INV     = (ACTIVE_LOW_AN != 0);
  localparam logic                HEX_EN     = (HEX_MODE != 0);
  localparam logic [6:0]          SEG_IDLE   = SEG_OFF ^ {7{SEG_INV}};
  localparam logic [N_DIGITS-1:0] AN_IDLE    = {N_DIGITS{AN_INV}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [VW-1:0]       pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [VW-1:0]       shad_val_q, shad_val_d;
  logic [N_DIGITS-1:0] shad_dp_q, shad_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                zero_above;
  logic [N_DIGITS-1:0] an_sel;
  logic [6:0]          glyph;

  // Prescaler and digit counter; both freeze while the display is disabled.
  always_comb begin
    tick    = enable && (presc_q == PRESC_LAST);
    wrap    = tick && (digit_q == DIGIT_LAST);
    presc_d = presc_q;
    digit_d = digit_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      digit_d = wrap ? '0 : digit_q + DW'(1);
    end
    frame_done_d = wrap;
  end

  // Pending/shadow staging: shadow only changes on the wrap to digit 0.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    shad_val_d   = shad_val_q;
    shad_dp_d    = shad_dp_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end
    if (wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        shad_val_d = value;
        shad_dp_d  = dp_mask;
      end else if (pend_valid_q) begin
        shad_val_d = pend_val_q;
        shad_dp_d  = pend_dp_q;
      end
    end
  end

  // Select the current digit's nibble/dp and decide leading-zero blanking by
  // scanning from the most significant digit down.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    an_sel     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (shad_val_q[4*i +: 4] == 4'h0);
      an_sel[i]  = (digit_q == DW'(i));
      if (digit_q == DW'(i)) begin
        cur_nib   = shad_val_q[4*i +: 4];
        cur_dp    = shad_dp_q[i];
        cur_blank = blank_lz && (i != 0) && zero_above;
      end
    end
  end

  seg7_glyph_decode u_glyph (
    .nibble   (cur_nib),
    .hex_mode (HEX_EN),
    .pattern  (glyph)
  );

  // Output register inputs: dark while disabled, otherwise the current digit.
  always_comb begin
    seg_d = SEG_IDLE;
    dp_d  = SEG_INV;
    an_d  = AN_IDLE;
    if (enable) begin
      seg_d = (cur_blank ? SEG_OFF : glyph) ^ {7{SEG_INV}};
      dp_d  = cur_dp ^ SEG_INV;
      an_d  = an_sel ^ AN_IDLE;
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      shad_val_q   <= '0;
      shad_dp_q    <= '0;
      seg_q        <= SEG_IDLE;
      dp_q         <= SEG_INV;
      an_q         <= AN_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      shad_val_q   <= shad_val_d;
      shad_dp_q    <= shad_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
